layer0_bias_sequencer: RTL and testbench

Sequences layer-0 post-accumulation processing for the keyword-spotting dense layer. It walks the neuron index 0..N_NEURONS-1 and drives the address of the combinational layer-0 bias ROM (Q8.8). For each neuron it accepts one Q16.16 accumulator result from the MAC array, adds the aligned bias, rescales to Q8.8 with saturation and optional ReLU, and hands the activation to the activation buffer over a valid/ready handshake.

---
 rtl/kws_pkg.sv | 27 ++
 rtl/q88_bias_relu.sv | 29 ++
 rtl/layer0_bias_sequencer.sv | 110 +++++++++++
 tb/tb_layer0_bias_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/kws_pkg.sv
// rtl/kws_pkg.sv - shared Q8.8 constants, sequencer state type and saturation helper
package kws_pkg;

    localparam int Q_FRAC = 8;
    localparam logic signed [15:0] Q88_MAX = 16'sh7FFF;
    localparam logic signed [15:0] Q88_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACC,
        EMIT,
        DONE
    } seq_state_t;

    // Drop the fractional alignment bits (floor) and clamp into Q8.8 range.
    function automatic logic signed [15:0] sat_q88(input logic signed [63:0] sum);
        logic signed [63:0] q;
        q = sum >>> Q_FRAC;
        if (q > 64'sd32767) begin
            return Q88_MAX;
        end else if (q < -64'sd32768) begin
            return Q88_MIN;
        end
        return q[15:0];
    endfunction

endpackage

// File: rtl/q88_bias_relu.sv
// rtl/q88_bias_relu.sv - combinational bias align/add, Q8.8 rescale with saturation and optional ReLU
module q88_bias_relu
    import kws_pkg::*;
#(
    parameter int ACC_W   = 32,
    parameter int RELU_EN = 1
) (
    input  logic [ACC_W-1:0] acc_data,
    input  logic [15:0]      bias_data,
    output logic [15:0]      act_data
);

    localparam int SW = ACC_W + 2;

    logic signed [SW-1:0] acc_ext;
    logic signed [SW-1:0] bias_ext;
    logic signed [SW-1:0] sum;
    logic signed [15:0]   sat;

    always_comb begin
        acc_ext  = {{2{acc_data[ACC_W-1]}}, acc_data};
        // Bias is Q8.8; shifting left by the fraction-width difference aligns it to Q.16.
        bias_ext = {{(SW-16){bias_data[15]}}, bias_data} <<< Q_FRAC;
        sum      = acc_ext + bias_ext;
        sat      = sat_q88({{(64-SW){sum[SW-1]}}, sum});
        act_data = ((RELU_EN != 0) && sat[15]) ? 16'h0000 : sat;
    end

endmodule

// File: rtl/layer0_bias_sequencer.sv
// rtl/layer0_bias_sequencer.sv - walks layer-0 neurons, applies bias/rescale, emits Q8.8 activations
module layer0_bias_sequencer
    import kws_pkg::*;
#(
    parameter int N_NEURONS = 256,
    parameter int ACC_W     = 32,
    parameter int RELU_EN   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [7:0]       bias_addr,
    input  logic [15:0]      bias_data,
    input  logic             acc_valid,
    output logic             acc_ready,
    input  logic [ACC_W-1:0] acc_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [7:0]       out_idx
);

    localparam logic [7:0] LAST_IDX = 8'(N_NEURONS - 1);

    seq_state_t  state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [15:0] out_data_q, out_data_d;
    logic [7:0]  out_idx_q, out_idx_d;
    logic [15:0] act_data;

    q88_bias_relu #(
        .ACC_W   (ACC_W),
        .RELU_EN (RELU_EN)
    ) u_bias_relu (
        .acc_data  (acc_data),
        .bias_data (bias_data),
        .act_data  (act_data)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        out_data_d = out_data_q;
        out_idx_d  = out_idx_q;
        unique case (state_q)
            IDLE: begin
                idx_d = 8'd0;
                if (start) begin
                    state_d = WAIT_ACC;
                end
            end
            WAIT_ACC: begin
                if (acc_valid) begin
                    out_data_d = act_data;
                    out_idx_d  = idx_q;
                    state_d    = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = WAIT_ACC;
                    end
                end
            end
            DONE: begin
                idx_d   = 8'd0;
                state_d = IDLE;
            end
            default: begin
                idx_d   = 8'd0;
                state_d = IDLE;
            end
        endcase
        // Abort overrides whatever handshake happened this cycle.
        if (abort) begin
            state_d = IDLE;
            idx_d   = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= 8'd0;
            out_data_q <= 16'h0000;
            out_idx_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            out_data_q <= out_data_d;
            out_idx_q  <= out_idx_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign acc_ready = (state_q == WAIT_ACC);
    assign out_valid = (state_q == EMIT);
    assign bias_addr = idx_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_layer0_bias_sequencer.sv
// tb/tb_layer0_bias_sequencer.sv - randomized and directed self-checking bench for layer0_bias_sequencer
module tb_layer0_bias_sequencer;

    typedef struct {
        int          idx;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // DUT A: full 256-neuron pass with ReLU, fed from a bench-side ROM.
    logic        start_a = 0, abort_a = 0, acc_valid_a = 0, out_ready_a = 0;
    logic [31:0] acc_data_a = 0;
    logic        busy_a, done_a, acc_ready_a, out_valid_a;
    logic [7:0]  bias_addr_a, out_idx_a;
    logic [15:0] bias_data_a, out_data_a;

    // DUT B: single neuron, signed (no ReLU) arithmetic cases.
    logic        start_b = 0, abort_b = 0, acc_valid_b = 0, out_ready_b = 0;
    logic [31:0] acc_data_b = 0;
    logic [15:0] bias_b = 0;
    logic        busy_b, done_b, acc_ready_b, out_valid_b;
    logic [7:0]  bias_addr_b, out_idx_b;
    logic [15:0] out_data_b;

    logic [15:0] rom [256];
    assign bias_data_a = rom[bias_addr_a];

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   outs = 0;
    int   exp_idx = 0;
    int   start_cyc = 0;
    int   done_cyc = 0;
    bit   mon_en = 1'b0;
    exp_t q[$];

    layer0_bias_sequencer #(.N_NEURONS(256), .ACC_W(32), .RELU_EN(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .busy(busy_a), .done(done_a), .bias_addr(bias_addr_a), .bias_data(bias_data_a),
        .acc_valid(acc_valid_a), .acc_ready(acc_ready_a), .acc_data(acc_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a), .out_idx(out_idx_a)
    );

    layer0_bias_sequencer #(.N_NEURONS(1), .ACC_W(32), .RELU_EN(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .busy(busy_b), .done(done_b), .bias_addr(bias_addr_b), .bias_data(bias_b),
        .acc_valid(acc_valid_b), .acc_ready(acc_ready_b), .acc_data(acc_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b), .out_idx(out_idx_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: real-valued bias add, floor to 1/256 steps, clamp, optional ReLU.
    function automatic logic [15:0] model_act(input logic [31:0] acc, input logic [15:0] bias, input bit relu);
        longint s, r;
        s = longint'($signed(acc)) + longint'($signed(bias)) * 256;
        r = s / 256;
        if ((s % 256) != 0 && s < 0) r = r - 1;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        if (relu && r < 0) r = 0;
        return r[15:0];
    endfunction

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (acc_ready_a && out_valid_a) chk("ready_valid_overlap", 1, 0);
            if (acc_ready_a) begin
                chk("bias_addr", bias_addr_a, 64'(exp_idx[7:0]));
                if (acc_valid_a) q.push_back('{exp_idx, model_act(acc_data_a, rom[exp_idx[7:0]], 1'b1)});
            end
            if (out_valid_a) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    chk("out_idx", out_idx_a, 64'(q[0].idx));
                    chk("out_data", out_data_a, q[0].data);
                    if (out_ready_a) begin
                        void'(q.pop_front());
                        outs++;
                        exp_idx++;
                    end
                end
            end
            if (done_a) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_after_last", outs, 256);
            end
        end
    end

    task automatic run_pass(input bit stall, output int len);
        int d0, n;
        d0 = done_cnt;
        q.delete();
        exp_idx = 0;
        outs = 0;
        @(posedge clk); #1;
        start_a = 1;
        start_cyc = cyc;
        acc_valid_a = 1;
        out_ready_a = 1;
        n = 0;
        while (done_cnt == d0 && n < 5000) begin
            @(posedge clk); #1;
            start_a = 0;
            if (n == 0) begin
                chk("start_acc_ready", acc_ready_a, 1);
                chk("start_bias_addr", bias_addr_a, 0);
            end
            acc_data_a  = $urandom;
            acc_valid_a = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            out_ready_a = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            n++;
        end
        acc_valid_a = 0;
        out_ready_a = 0;
        chk("pass_done_seen", done_cnt, d0 + 1);
        chk("pass_outputs", outs, 256);
        chk("busy_after_done", busy_a, 0);
        @(posedge clk); #1;
        chk("single_done_pulse", done_cnt, d0 + 1);
        len = done_cyc - start_cyc + 1;
    endtask

    task automatic b_case(input string name, input logic [31:0] acc, input logic [15:0] bias,
                          input logic [15:0] exp);
        int n;
        @(posedge clk); #1;
        bias_b = bias; acc_data_b = acc; acc_valid_b = 1; start_b = 1; out_ready_b = 0;
        @(posedge clk); #1;
        start_b = 0;
        n = 0;
        while (!out_valid_b && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        acc_valid_b = 0;
        chk({name, "_valid"}, out_valid_b, 1);
        chk({name, "_data"}, out_data_b, exp);
        chk({name, "_model"}, out_data_b, model_act(acc, bias, 1'b0));
        chk({name, "_idx"}, out_idx_b, 0);
        out_ready_b = 1;
        @(posedge clk); #1;
        out_ready_b = 0;
        chk({name, "_done"}, done_b, 1);
        @(posedge clk); #1;
        chk({name, "_idle"}, busy_b, 0);
    endtask

    initial begin
        int len, n;
        bit found;
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int len, n, d0;
        bit found;
        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);

        chk("model_pin_pos", model_act(32'h0001_0000, 16'hFF87, 1'b0), 16'h0087);
        chk("model_pin_relu", model_act(32'h0, 16'hFF87, 1'b1), 16'h0000);
        chk("model_pin_neg", model_act(32'h0, 16'hFF87, 1'b0), 16'hFF87);
        chk("model_pin_max", model_act(32'h7FFF_FF00, 16'h00FF, 1'b0), 16'h7FFF);
        chk("model_pin_min", model_act(32'h8000_0000, 16'hFF00, 1'b0), 16'h8000);

        #1;
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_acc_ready", acc_ready_a, 0);
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_out_data", out_data_a, 0);
        chk("rst_out_idx", out_idx_a, 0);
        chk("rst_bias_addr", bias_addr_a, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        b_case("b_pos", 32'h0001_0000, 16'hFF87, 16'h0087);
        b_case("b_neg", 32'h0000_0000, 16'hFF87, 16'hFF87);
        b_case("b_sat_max", 32'h7FFF_FF00, 16'h00FF, 16'h7FFF);
        b_case("b_sat_min", 32'h8000_0000, 16'hFF00, 16'h8000);

        mon_en = 1;
        q.delete(); exp_idx = 0; outs = 0;
        rom[0] = 16'hFF87;
        @(posedge clk); #1;
        start_a = 1; acc_valid_a = 1; acc_data_a = 32'h0; out_ready_a = 0;
        @(posedge clk); #1;
        start_a = 0;
        @(posedge clk); #1;
        acc_valid_a = 0;
        chk("a_relu_valid", out_valid_a, 1);
        chk("a_relu_data", out_data_a, 16'h0000);
        abort_a = 1;
        @(posedge clk); #1;
        abort_a = 0;
        chk("a_relu_abort_idle", busy_a, 0);

        q.delete(); exp_idx = 0; outs = 0;
        @(posedge clk); #1;
        start_a = 1; acc_valid_a = 1; acc_data_a = 32'h0001_0000; out_ready_a = 0;
        @(posedge clk); #1;
        start_a = 0;
        @(posedge clk); #1;
        acc_valid_a = 0;
        chk("a_pos_data", out_data_a, 16'h0087);
        chk("a_pos_valid", out_valid_a, 1);
        mon_en = 0;
        #2 rst_n = 0;
        #1;
        chk("async_rst_busy", busy_a, 0);
        chk("async_rst_out_valid", out_valid_a, 0);
        chk("async_rst_out_data", out_data_a, 0);
        chk("async_rst_acc_ready", acc_ready_a, 0);
        chk("async_rst_done", done_a, 0);
        @(posedge clk); #1;
        rst_n = 1;
        mon_en = 1;

        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
        rom[3] = 16'h7FFF; rom[4] = 16'h8000;
        run_pass(1'b1, len);
        run_pass(1'b0, len);
        chk("nostall_pass_len", len, 514);

        q.delete(); exp_idx = 0; outs = 0;
        d0 = done_cnt;
        @(posedge clk); #1;
        start_a = 1; acc_valid_a = 1; out_ready_a = 1;
        found = 0;
        n = 0;
        while (!found && n < 1000) begin
            @(posedge clk); #1;
            start_a = 0;
            acc_data_a = $urandom;
            if (out_valid_a && out_idx_a == 8'd100) begin
                out_ready_a = 0;
                abort_a = 1;
                found = 1;
            end
            n++;
        end
        chk("abort_reached_idx100", found, 1);
        @(posedge clk); #1;
        abort_a = 0;
        acc_valid_a = 0;
        chk("abort_busy", busy_a, 0);
        chk("abort_out_valid", out_valid_a, 0);
        chk("abort_bias_addr", bias_addr_a, 0);
        chk("abort_done", done_a, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done_pulse", done_cnt, d0);

        run_pass(1'b0, len);
        chk("restart_pass_len", len, 514);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
